coproc_unit: RTL and testbench

Parametrised multi-op integer coprocessor and successor to the fixed 8-bit GCD/LCM unit. Computes GCD, LCM or MOD of two unsigned WIDTH-bit operands by iterative subtract/add. Uses a ready/start/done handshake and reports an error for illegal operations. Sits beside the RISC-V core as a slow functional unit; the core polls done or waits on it.

---
 rtl/coproc_pkg.sv | 14 +
 rtl/coproc_if.sv | 29 ++
 rtl/coproc_datapath.sv | 49 ++++
 rtl/coproc_unit.sv | 88 ++++++++
 tb/tb_coproc_unit.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/coproc_pkg.sv
// coproc_pkg: shared types and defaults for the GCD/LCM/MOD coprocessor.
package coproc_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {OP_GCD, OP_LCM, OP_MOD, OP_RSVD} op_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef struct packed {
    logic za;
    logic zb;
    logic zx;
    logic zy;
    logic eq;
    logic lt;
  } dp_flags_t;
endpackage

// File: rtl/coproc_if.sv
// coproc_if: start/done handshake between the core and the coprocessor.
// The cycles signal exists only when COPROC_CYCLE_CNT_EN is defined.
interface coproc_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] x0;
  logic [WIDTH-1:0] y0;
  logic             ready;
  logic             busy;
  logic             done;
  logic             err;
  logic [2*WIDTH-1:0] result;
`ifdef COPROC_CYCLE_CNT_EN
  logic [CNT_W-1:0] cycles;
`endif
  modport master (output start, op, x0, y0, input ready, busy, done, err, result
`ifdef COPROC_CYCLE_CNT_EN
    , cycles
`endif
  );
  modport slave (input start, op, x0, y0, output ready, busy, done, err, result
`ifdef COPROC_CYCLE_CNT_EN
    , cycles
`endif
  );
endinterface

// File: rtl/coproc_datapath.sv
// coproc_datapath: operand registers and the subtract/add iteration step.
// For MOD, a holds the remainder and b holds the divisor, so one step rule serves GCD and MOD.
module coproc_datapath import coproc_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  op_e              op_i,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  output op_e              op_q,
  output logic [2*WIDTH-1:0] a,
  output logic [2*WIDTH-1:0] b,
  output dp_flags_t        f
);
  localparam int W2 = 2 * WIDTH;
  logic [W2-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  op_e op_d;
  assign f = {a_q == '0, b_q == '0, x_q == '0, y_q == '0, a_q == b_q, a_q < b_q};
  assign a = a_q;
  assign b = b_q;
  always_comb begin
    op_d = load ? op_i : op_q;
    x_d = load ? x0 : x_q;
    y_d = load ? y0 : y_q;
    a_d = load ? W2'(x0) : !step ? a_q :
          op_q == OP_LCM ? (f.lt ? a_q + W2'(x_q) : a_q) : (f.lt ? a_q : a_q - b_q);
    b_d = load ? W2'(y0) : !step ? b_q :
          op_q == OP_LCM ? (f.lt ? b_q : b_q + W2'(y_q)) : (f.lt ? b_q - a_q : b_q);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q <= OP_GCD;
      x_q  <= '0;
      y_q  <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else begin
      op_q <= op_d;
      x_q  <= x_d;
      y_q  <= y_d;
      a_q  <= a_d;
      b_q  <= b_d;
    end
  end
endmodule

// File: rtl/coproc_unit.sv
// coproc_unit: iterative GCD/LCM/MOD coprocessor with ready/start/done handshake.
// Define COPROC_CYCLE_CNT_EN to add the saturating RUN-cycle counter on bus.cycles.
module coproc_unit import coproc_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 16
) (
  input logic     clk,
  input logic     reset,
  coproc_if.slave bus
);
  localparam int W2 = 2 * WIDTH;
  state_e state_q, state_d;
  op_e op_q;
  dp_flags_t f;
  logic err_q, err_d, term, term_err, load, step;
  logic [W2-1:0] res_q, res_d, term_res, a, b;
  coproc_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk(clk), .reset(reset), .load(load), .step(step), .op_i(op_e'(bus.op)),
    .x0(bus.x0), .y0(bus.y0), .op_q(op_q), .a(a), .b(b), .f(f)
  );
  assign load = state_q == S_IDLE && bus.start;
  assign step = state_q == S_RUN && !term;
  // The terminal check takes priority over stepping in every RUN cycle.
  always_comb begin
    term = 1'b1;
    term_err = 1'b0;
    term_res = '0;
    case (op_q)
      OP_GCD: begin
        term = f.za | f.zb | f.eq;
        term_res = f.za ? b : a;
      end
      OP_LCM: begin
        term = f.zx | f.zy | f.eq;
        term_res = (f.zx | f.zy) ? '0 : a;
      end
      OP_MOD: begin
        term = f.zy | f.lt;
        term_err = f.zy;
        term_res = f.zy ? '0 : a;
      end
      default: term_err = 1'b1;
    endcase
  end
  always_comb begin
    state_d = state_q;
    err_d = err_q;
    res_d = res_q;
    case (state_q)
      S_IDLE: begin
        state_d = bus.start ? S_RUN : S_IDLE;
        err_d = bus.start ? 1'b0 : err_q;
        res_d = bus.start ? '0 : res_q;
      end
      S_RUN: begin
        state_d = term ? S_DONE : S_RUN;
        err_d = term ? term_err : err_q;
        res_d = term ? term_res : res_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      res_q   <= res_d;
    end
  end
  assign bus.ready  = state_q == S_IDLE;
  assign bus.busy   = state_q == S_RUN;
  assign bus.done   = state_q == S_DONE;
  assign bus.err    = err_q;
  assign bus.result = res_q;
`ifdef COPROC_CYCLE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = load ? '0 : (state_q == S_RUN && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign bus.cycles = cnt_q;
`endif
endmodule

// File: tb/tb_coproc_unit.sv
// tb_coproc_unit: directed scoreboard bench for coproc_unit (WIDTH=8).
module tb_coproc_unit;
  localparam int W = 8;
  typedef struct {
    logic [2*W-1:0] res;
    logic           err;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t sb[$];
  logic [1:0]   s_op[4];
  logic [W-1:0] s_x[4];
  logic [W-1:0] s_y[4];
  coproc_if #(.WIDTH(W)) bus();
  coproc_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int unsigned g = x, h = y, t;
    e.err = 1'b0;
    e.res = '0;
    while (h != 0) begin
      t = g % h;
      g = h;
      h = t;
    end
    case (o)
      2'b00: e.res = (2*W)'(g);
      2'b01: e.res = (x == 0 || y == 0) ? '0 : (2*W)'((int'(x) * int'(y)) / g);
      2'b10: if (y == 0) e.err = 1'b1; else e.res = (2*W)'(x % y);
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int lat);
    exp_t e;
    int n = 0;
    sb.push_back(model(o, x, y));
    while (!bus.ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(bus.ready), 1);
    bus.start = 1'b1;
    bus.op = o;
    bus.x0 = x;
    bus.y0 = y;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = 2'($urandom);
    bus.x0 = W'($urandom);
    bus.y0 = W'($urandom);
    chk({tag, "_busy"}, 32'(bus.busy), 1);
    n = 0;
    while (!bus.done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(bus.done), 1);
    e = sb.pop_front();
    chk({tag, "_res"}, 32'(bus.result), 32'(e.res));
    chk({tag, "_err"}, 32'(bus.err), 32'(e.err));
    if (lat > 0) chk({tag, "_lat"}, n, lat);
    @(negedge clk);
    chk({tag, "_pulse"}, {bus.done, bus.ready}, 2'b01);
    chk({tag, "_hold"}, {bus.err, bus.result}, {e.err, e.res});
  endtask
  // Start stays high the whole time; each IDLE visit must take exactly the operands shown then.
  task automatic stream(input string tag, input int cnt);
    exp_t e;
    int i = 0, d = 0, t = 0, done_cyc = 0;
    bit pr = 1'b0;
    while (d < cnt && t < 3000) begin
      bus.start = i < cnt;
      if (bus.ready) chk({tag, "_one_accept"}, 32'(pr), 0);
      pr = bus.ready;
      if (bus.ready && i < cnt) begin
        if (i > 0) chk({tag, "_gap"}, cyc + 1 - done_cyc, 2);
        sb.push_back(model(s_op[i], s_x[i], s_y[i]));
        bus.op = s_op[i];
        bus.x0 = s_x[i];
        bus.y0 = s_y[i];
        i++;
      end else begin
        bus.op = 2'($urandom);
        bus.x0 = W'($urandom);
        bus.y0 = W'($urandom);
      end
      if (bus.done) begin
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({tag, "_res"}, 32'(bus.result), 32'(e.res));
          chk({tag, "_err"}, 32'(bus.err), 32'(e.err));
        end
        done_cyc = cyc;
        d++;
      end
      @(negedge clk);
      t++;
    end
    bus.start = 1'b0;
    chk({tag, "_count"}, d, cnt);
    chk({tag, "_accepts"}, i, cnt);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.x0 = '0;
    bus.y0 = '0;
    #12;
    chk("rst_ready", 32'(bus.ready), 1);
    chk("rst_busy_done", {bus.busy, bus.done}, 0);
    chk("rst_err_res", {bus.err, bus.result}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_op("gcd_12_8", 2'b00, 8'd12, 8'd8, 3);
`ifdef COPROC_CYCLE_CNT_EN
    chk("gcd_12_8_cycles", 32'(bus.cycles), 3);
`endif
    do_op("gcd_0_9", 2'b00, 8'd0, 8'd9, 1);
    do_op("gcd_0_0", 2'b00, 8'd0, 8'd0, 1);
    do_op("gcd_7_7", 2'b00, 8'd7, 8'd7, 1);
    do_op("lcm_4_6", 2'b01, 8'd4, 8'd6, 0);
    do_op("lcm_255_254", 2'b01, 8'd255, 8'd254, 0);
    do_op("lcm_0_5", 2'b01, 8'd0, 8'd5, 1);
    do_op("mod_17_5", 2'b10, 8'd17, 8'd5, 4);
    do_op("mod_7_0", 2'b10, 8'd7, 8'd0, 1);
    do_op("mod_3_9", 2'b10, 8'd3, 8'd9, 1);
    do_op("rsvd", 2'b11, 8'd21, 8'd14, 1);
    bus.start = 1'b1;
    bus.op = 2'b00;
    bus.x0 = 8'd200;
    bus.y0 = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("rstmid_busy_before", 32'(bus.busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("rstmid_ready", 32'(bus.ready), 1);
    chk("rstmid_busy_done", {bus.busy, bus.done}, 0);
    chk("rstmid_err_res", {bus.err, bus.result}, 0);
    repeat (3) @(negedge clk);
    chk("rstmid_no_done", 32'(bus.done), 0);
    reset = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      s_op[k] = 2'b00;
      s_x[k] = W'($urandom_range(1, 40));
      s_y[k] = W'($urandom_range(1, 40));
    end
    stream("held", 3);
    @(negedge clk);
    s_op[0] = 2'b00;
    s_x[0] = 8'd9;
    s_y[0] = 8'd6;
    s_op[1] = 2'b01;
    s_x[1] = 8'd3;
    s_y[1] = 8'd5;
    stream("b2b", 2);
    chk("b2b_final_res", 32'(bus.result), 15);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
